// File: rtl/mbc_control.sv
// Timing-and-control sequencer for the 16-bit basic computer: IR, I, SC (T0..T6) and per-cycle strobes.
// Optional I/O instruction decode (fgi/fgo inputs, inp_ld/out_ld outputs) is enabled by defining MBC_IO_EN.
module mbc_control #(
   parameter int SC_W   = 3,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       mem_data,
   input  logic              alu_skip,
   input  logic              dr_zero,
`ifdef MBC_IO_EN
   input  logic              fgi,
   input  logic              fgo,
   output logic              inp_ld,
   output logic              out_ld,
`endif
   output logic [3:0]        alu_code,
   output logic              ac_we,
   output logic              e_we,
   output logic              ar_ld_pc,
   output logic              ar_ld_ir,
   output logic              ar_ld_mem,
   output logic              ar_inc,
   output logic              pc_inc,
   output logic              pc_ld_ar,
   output logic              dr_ld,
   output logic              dr_inc,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [1:0]        mem_wsel,
   output logic [ADDR_W-1:0] ir_addr,
   output logic [SC_W-1:0]   sc,
   output logic              running
);

   typedef enum logic [SC_W-1:0] {T0, T1, T2, T3, T4, T5, T6} tstate_e;

   tstate_e     t_q, t_d;
   logic        run_q, run_d;
   logic [15:0] ir_q;
   logic        i_q;
   logic [2:0]  opc;
   logic        done;

   assign opc     = ir_q[14:12];
   assign ir_addr = ir_q[ADDR_W-1:0];
   assign sc      = t_q;
   assign running = run_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t_q   <= T0;
         run_q <= 1'b0;
         ir_q  <= '0;
         i_q   <= 1'b0;
      end else begin
         t_q   <= t_d;
         run_q <= run_d;
         if (run_q && t_q == T1) ir_q <= mem_data;
         if (run_q && t_q == T2) i_q  <= ir_q[15];
      end
   end

   always_comb begin
      t_d       = t_q;
      run_d     = run_q;
      done      = 1'b0;
      alu_code  = 4'b1111;
      ac_we     = 1'b0;
      e_we      = 1'b0;
      ar_ld_pc  = 1'b0;
      ar_ld_ir  = 1'b0;
      ar_ld_mem = 1'b0;
      ar_inc    = 1'b0;
      pc_inc    = 1'b0;
      pc_ld_ar  = 1'b0;
      dr_ld     = 1'b0;
      dr_inc    = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_wsel  = 2'd0;
`ifdef MBC_IO_EN
      inp_ld    = 1'b0;
      out_ld    = 1'b0;
`endif
      if (!run_q) begin
         if (start) begin
            run_d = 1'b1;
            t_d   = T0;
         end
      end else begin
         t_d = tstate_e'(t_q + 1'b1);
         case (t_q)
            T0: ar_ld_pc = 1'b1;
            T1: begin
               mem_rd = 1'b1;
               pc_inc = 1'b1;
            end
            T2: ar_ld_ir = 1'b1;
            T3: begin
               if (opc == 3'd7) begin
                  done = 1'b1;
                  if (!i_q) begin
                     // Register-reference: only the highest set bit of IR[11:0] executes.
                     casez (ir_q[11:0])
                        12'b1???????????: begin alu_code = 4'b0110; ac_we = 1'b1; end
                        12'b01??????????: begin alu_code = 4'b1000; e_we = 1'b1; end
                        12'b001?????????: begin alu_code = 4'b0011; ac_we = 1'b1; end
                        12'b0001????????: begin alu_code = 4'b1001; e_we = 1'b1; end
                        12'b00001???????: begin alu_code = 4'b0100; ac_we = 1'b1; e_we = 1'b1; end
                        12'b000001??????: begin alu_code = 4'b0101; ac_we = 1'b1; e_we = 1'b1; end
                        12'b0000001?????: begin alu_code = 4'b0111; ac_we = 1'b1; end
                        12'b00000001????: begin alu_code = 4'b1010; pc_inc = alu_skip; end
                        12'b000000001???: begin alu_code = 4'b1011; pc_inc = alu_skip; end
                        12'b0000000001??: begin alu_code = 4'b1100; pc_inc = alu_skip; end
                        12'b00000000001?: begin alu_code = 4'b1101; pc_inc = alu_skip; end
                        12'b000000000001: run_d = 1'b0;
                        default: ;
                     endcase
                  end else begin
`ifdef MBC_IO_EN
                     casez (ir_q[11:8])
                        4'b1???: inp_ld = 1'b1;
                        4'b01??: out_ld = 1'b1;
                        4'b001?: pc_inc = fgi;
                        4'b0001: pc_inc = fgo;
                        default: ;
                     endcase
`else
                     // Without the I/O option every I/O instruction is a NOP.
`endif
                  end
               end else if (i_q) begin
                  ar_ld_mem = 1'b1;
                  mem_rd    = 1'b1;
               end
            end
            T4: begin
               case (opc)
                  3'd0, 3'd1, 3'd2, 3'd6: begin
                     dr_ld  = 1'b1;
                     mem_rd = 1'b1;
                  end
                  3'd3: begin
                     mem_wr = 1'b1;
                     done   = 1'b1;
                  end
                  3'd4: begin
                     pc_ld_ar = 1'b1;
                     done     = 1'b1;
                  end
                  3'd5: begin
                     mem_wr   = 1'b1;
                     mem_wsel = 2'd1;
                     ar_inc   = 1'b1;
                  end
                  default: done = 1'b1;
               endcase
            end
            T5: begin
               case (opc)
                  3'd0: begin alu_code = 4'b0000; ac_we = 1'b1; done = 1'b1; end
                  3'd1: begin alu_code = 4'b0001; ac_we = 1'b1; e_we = 1'b1; done = 1'b1; end
                  3'd2: begin alu_code = 4'b0010; ac_we = 1'b1; done = 1'b1; end
                  3'd5: begin pc_ld_ar = 1'b1; done = 1'b1; end
                  3'd6: dr_inc = 1'b1;
                  default: done = 1'b1;
               endcase
            end
            T6: begin
               mem_wr   = 1'b1;
               mem_wsel = 2'd2;
               pc_inc   = dr_zero;
               done     = 1'b1;
            end
            default: done = 1'b1;
         endcase
         if (done) t_d = T0;
      end
   end

endmodule

// File: tb/tb_mbc_control.sv
// Self-checking bench for mbc_control: instruction-level model of expected strobes per timing cycle.
// Handshake: start is a level sampled at the rising edge while stopped; inputs change 1ns after the edge, outputs compared on the falling edge.
module tb_mbc_control;
   localparam int W = 34;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] mem_data;
   logic        alu_skip, dr_zero;
   logic [3:0]  alu_code;
   logic        ac_we, e_we, ar_ld_pc, ar_ld_ir, ar_ld_mem, ar_inc;
   logic        pc_inc, pc_ld_ar, dr_ld, dr_inc, mem_rd, mem_wr;
   logic [1:0]  mem_wsel;
   logic [11:0] ir_addr;
   logic [2:0]  sc;
   logic        running;

   typedef struct packed {
      logic [3:0]  code;
      logic        ac_we, e_we, ar_ld_pc, ar_ld_ir, ar_ld_mem, ar_inc;
      logic        pc_inc, pc_ld_ar, dr_ld, dr_inc, mem_rd, mem_wr;
      logic [1:0]  wsel;
      logic [11:0] addr;
      logic [2:0]  sc;
      logic        running;
   } obs_t;

   logic [W-1:0] act;
   logic [W-1:0] exp_q[$];
   string        tag_q[$];
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [11:0]  cur_addr;

   always #5 clk = ~clk;

   mbc_control dut (
      .clk(clk), .rst(rst), .start(start), .mem_data(mem_data),
      .alu_skip(alu_skip), .dr_zero(dr_zero), .alu_code(alu_code),
      .ac_we(ac_we), .e_we(e_we), .ar_ld_pc(ar_ld_pc), .ar_ld_ir(ar_ld_ir),
      .ar_ld_mem(ar_ld_mem), .ar_inc(ar_inc), .pc_inc(pc_inc), .pc_ld_ar(pc_ld_ar),
      .dr_ld(dr_ld), .dr_inc(dr_inc), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wsel(mem_wsel), .ir_addr(ir_addr), .sc(sc), .running(running)
   );

   assign act = {alu_code, ac_we, e_we, ar_ld_pc, ar_ld_ir, ar_ld_mem, ar_inc,
                 pc_inc, pc_ld_ar, dr_ld, dr_inc, mem_rd, mem_wr, mem_wsel,
                 ir_addr, sc, running};

   // Number of timing cycles an instruction occupies, from the instruction table.
   function automatic int ins_len(input logic [15:0] ins);
      case (ins[14:12])
         3'd7:       return 4;
         3'd3, 3'd4: return 5;
         3'd6:       return 7;
         default:    return 6;
      endcase
   endfunction

   function automatic obs_t idle_vec(input logic [11:0] prev);
      obs_t o;
      o      = '0;
      o.code = 4'hF;
      o.addr = prev;
      return o;
   endfunction

   // Expected outputs of cycle t of instruction ins.
   function automatic obs_t model(input logic [15:0] ins, input int t, input logic sk,
                                  input logic dz, input logic [11:0] prev);
      obs_t o;
      int   d, h;
      o         = '0;
      o.code    = 4'hF;
      o.sc      = t[2:0];
      o.running = 1'b1;
      o.addr    = (t < 2) ? prev : ins[11:0];
      d         = int'(ins[14:12]);
      if (t == 0) o.ar_ld_pc = 1'b1;
      if (t == 1) begin o.mem_rd = 1'b1; o.pc_inc = 1'b1; end
      if (t == 2) o.ar_ld_ir = 1'b1;
      if (t == 3 && d == 7 && !ins[15]) begin
         h = -1;
         for (int b = 0; b < 12; b++) if (ins[b]) h = b;
         case (h)
            11: begin o.code = 4'b0110; o.ac_we = 1'b1; end
            10: begin o.code = 4'b1000; o.e_we = 1'b1; end
            9:  begin o.code = 4'b0011; o.ac_we = 1'b1; end
            8:  begin o.code = 4'b1001; o.e_we = 1'b1; end
            7:  begin o.code = 4'b0100; o.ac_we = 1'b1; o.e_we = 1'b1; end
            6:  begin o.code = 4'b0101; o.ac_we = 1'b1; o.e_we = 1'b1; end
            5:  begin o.code = 4'b0111; o.ac_we = 1'b1; end
            4:  begin o.code = 4'b1010; o.pc_inc = sk; end
            3:  begin o.code = 4'b1011; o.pc_inc = sk; end
            2:  begin o.code = 4'b1100; o.pc_inc = sk; end
            1:  begin o.code = 4'b1101; o.pc_inc = sk; end
            default: ;
         endcase
      end
      if (t == 3 && d != 7 && ins[15]) begin o.ar_ld_mem = 1'b1; o.mem_rd = 1'b1; end
      if (t == 4) begin
         if (d <= 2 || d == 6) begin o.dr_ld = 1'b1; o.mem_rd = 1'b1; end
         if (d == 3) o.mem_wr = 1'b1;
         if (d == 4) o.pc_ld_ar = 1'b1;
         if (d == 5) begin o.mem_wr = 1'b1; o.wsel = 2'd1; o.ar_inc = 1'b1; end
      end
      if (t == 5) begin
         if (d == 0) begin o.code = 4'b0000; o.ac_we = 1'b1; end
         if (d == 1) begin o.code = 4'b0001; o.ac_we = 1'b1; o.e_we = 1'b1; end
         if (d == 2) begin o.code = 4'b0010; o.ac_we = 1'b1; end
         if (d == 5) o.pc_ld_ar = 1'b1;
         if (d == 6) o.dr_inc = 1'b1;
      end
      if (t == 6) begin o.mem_wr = 1'b1; o.wsel = 2'd2; o.pc_inc = dz; end
      return o;
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         string        tg;
         e  = exp_q.pop_front();
         tg = tag_q.pop_front();
         n_tests++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tg, act, e);
         end
      end
   end

   task automatic check_lit(input string name, input logic [15:0] got, input logic [15:0] expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, expv);
      end
   endtask

   task automatic step(input obs_t e, input string tag, input logic st, input logic sk,
                       input logic dz, input logic [15:0] md);
      @(posedge clk);
      #1;
      start    = st;
      alu_skip = sk;
      dr_zero  = dz;
      mem_data = md;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) step(idle_vec(cur_addr), "idle", 1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic start_cpu();
      step(idle_vec(cur_addr), "start", 1'b1, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic run_instr(input logic [15:0] ins, input logic sk, input logic dz,
                            input logic hs, input int n_max);
      int n;
      n = ins_len(ins);
      if (n_max < n) n = n_max;
      for (int t = 0; t < n; t++)
         step(model(ins, t, sk, dz, cur_addr), $sformatf("%h_T%0d", ins, t), hs, sk, dz, ins);
      cur_addr = ins[11:0];
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b1;
      mem_data = 16'h0;
      alu_skip = 1'b0;
      dr_zero  = 1'b0;
      cur_addr = 12'h0;

      check_lit("pin_cla_code", 16'(model(16'h7800, 3, 1'b0, 1'b0, 12'h0).code), 16'h0006);
      check_lit("pin_add_len", 16'(ins_len(16'h1005)), 16'd6);
      check_lit("pin_isz_wsel", 16'(model(16'h6010, 6, 1'b0, 1'b1, 12'h0).wsel), 16'd2);
      check_lit("pin_sza_skip", 16'(model(16'h7004, 3, 1'b1, 1'b0, 12'h0).pc_inc), 16'd1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_lit("rst_sc", 16'(sc), 16'd0);
      check_lit("rst_running", 16'(running), 16'd0);
      check_lit("rst_alu_code", 16'(alu_code), 16'h000F);
      check_lit("rst_wsel", 16'(mem_wsel), 16'd0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      idle_cycles(2);

      start_cpu();
      run_instr(16'h7800, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h1005, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h9005, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h7004, 1'b1, 1'b0, 1'b0, 99);
      run_instr(16'h7004, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h6010, 1'b0, 1'b1, 1'b0, 99);
      run_instr(16'h6010, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h2007, 1'b0, 1'b0, 1'b1, 99);
      run_instr(16'h0008, 1'b0, 1'b0, 1'b1, 99);
      run_instr(16'h3009, 1'b0, 1'b0, 1'b1, 99);
      run_instr(16'h400A, 1'b0, 1'b0, 1'b1, 99);
      run_instr(16'h500B, 1'b0, 1'b0, 1'b1, 99);
      run_instr(16'hC00C, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h7C00, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h7200, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h7100, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h7080, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h7040, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h7020, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h7010, 1'b1, 1'b0, 1'b0, 99);
      run_instr(16'h7008, 1'b1, 1'b0, 1'b0, 99);
      run_instr(16'h7002, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h7003, 1'b1, 1'b0, 1'b0, 99);
      run_instr(16'h7000, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'hF800, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h7001, 1'b0, 1'b0, 1'b0, 99);
      idle_cycles(3);

      start_cpu();
      run_instr(16'h1005, 1'b0, 1'b0, 1'b0, 5);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check_lit("midrst_sc", 16'(sc), 16'd0);
      check_lit("midrst_ac_we", 16'(ac_we), 16'd0);
      check_lit("midrst_running", 16'(running), 16'd0);
      check_lit("midrst_alu_code", 16'(alu_code), 16'h000F);
      check_lit("midrst_ir_addr", 16'(ir_addr), 16'h0000);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      cur_addr = 12'h0;
      idle_cycles(2);

      start_cpu();
      run_instr(16'h7800, 1'b0, 1'b0, 1'b0, 99);
      run_instr(16'h7001, 1'b0, 1'b0, 1'b0, 99);
      idle_cycles(2);

      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
